// File: rtl/evm_pkg.sv
// Shared constants for the voting machine: FSM/mode encodings and default sizes
// used by both vote_logger and the debouncer bank top.
package evm_pkg;

  localparam logic ST_IDLE     = 1'b0;
  localparam logic ST_ARMED    = 1'b1;

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  localparam int DEF_NUM_CAND  = 4;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones maximum instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/vote_logger.sv
// Records one vote per presiding-officer arm into per-candidate saturating tallies
// and drives the LED bank; define VOTE_TOTAL_EN to add the total_votes output.
module vote_logger
  import evm_pkg::*;
#(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        arm,
  input  logic [NUM_CAND-1:0]         valid_vote,
  input  logic [$clog2(NUM_CAND)-1:0] sel,
  output logic                        ready,
  output logic                        vote_ack,
  output logic                        collision,
  output logic [CNT_W-1:0]            leds
`ifdef VOTE_TOTAL_EN
  ,
  output logic [CNT_W+$clog2(NUM_CAND)-1:0] total_votes
`endif
);

  localparam int SEL_W = $clog2(NUM_CAND);

  state_t              state;
  state_t              state_next;
  logic [NUM_CAND-1:0] inc;
  logic                ack_next;
  logic                coll_next;
  logic                one_hot;
  logic                multi;
  logic [CNT_W-1:0]    leds_next;
  logic [CNT_W-1:0]    tally [NUM_CAND];

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi   = |(valid_vote & (valid_vote - NUM_CAND'(1)));
  assign one_hot = (|valid_vote) && !multi;

  assign ready = (state == ARMED);

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_tally
    sat_counter #(.W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (inc[i]),
      .count (tally[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      vote_ack  <= 1'b0;
      collision <= 1'b0;
      leds      <= '0;
    end else begin
      state     <= state_next;
      vote_ack  <= ack_next;
      collision <= coll_next;
      leds      <= leds_next;
    end
  end

  // Switching to result mode always disarms, even if a vote arrives in the same cycle.
  always_comb begin
    state_next = state;
    inc        = '0;
    ack_next   = 1'b0;
    coll_next  = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_VOTE && arm)
          state_next = ARMED;
      end
      ARMED: begin
        if (mode == MODE_RESULT) begin
          state_next = IDLE;
        end else if (one_hot) begin
          inc        = valid_vote;
          ack_next   = 1'b1;
          state_next = IDLE;
        end else if (multi) begin
          coll_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef VOTE_TOTAL_EN
  logic [CNT_W+SEL_W-1:0] total;
  logic [NUM_CAND-1:0]    sat;

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_sat
    assign sat[i] = &tally[i];
  end

  // A vote is one-hot, so the sum of tallies grows by one unless that tally is pinned.
  always_ff @(posedge clock) begin
    if (reset)
      total <= '0;
    else if (|(inc & ~sat))
      total <= total + (CNT_W+SEL_W)'(1);
  end

  assign total_votes = total;
`endif

  always_comb begin
    leds_next = '0;
    if (mode == MODE_RESULT) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (sel == SEL_W'(i))
          leds_next = tally[i];
      end
`ifdef VOTE_TOTAL_EN
      if (int'(sel) == NUM_CAND)
        leds_next = total[CNT_W-1:0];
`endif
    end else begin
      leds_next = {{(CNT_W-1){1'b0}}, (state_next == ARMED)};
    end
  end

endmodule

// File: tb/tb_vote_logger.sv
// Directed, table-driven bench for vote_logger with hand-computed expectations;
// extra total_votes checks are compiled in when VOTE_TOTAL_EN is defined.
module tb_vote_logger;
  import evm_pkg::*;

  localparam int NUM_CAND = 4;
  localparam int CNT_W    = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       arm;
  logic [3:0] valid_vote;
  logic [1:0] sel;
  logic       ready;
  logic       vote_ack;
  logic       collision;
  logic [7:0] leds;
`ifdef VOTE_TOTAL_EN
  logic [9:0] total_votes;
`endif

  int checks = 0;
  int passes = 0;
  int ack_cnt;

  typedef struct {
    logic       mode;
    logic       arm;
    logic [3:0] valid;
    logic [1:0] sel;
    logic       ready;
    logic       ack;
    logic       coll;
    logic [7:0] leds;
  } vec_t;

  vec_t vecs[$];

  vote_logger #(.NUM_CAND(NUM_CAND), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .arm         (arm),
    .valid_vote  (valid_vote),
    .sel         (sel),
    .ready       (ready),
    .vote_ack    (vote_ack),
    .collision   (collision),
    .leds        (leds)
`ifdef VOTE_TOTAL_EN
    ,
    .total_votes (total_votes)
`endif
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are read one falling edge later.
  task automatic apply_stimulus(input logic m, input logic a, input logic [3:0] v,
                                input logic [1:0] s);
    mode       = m;
    arm        = a;
    valid_vote = v;
    sel        = s;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cast_vote(input int cand, input string name);
    apply_stimulus(MODE_VOTE, 1'b1, 4'b0000, 2'd0);
    apply_stimulus(MODE_VOTE, 1'b0, 4'(1 << cand), 2'd0);
    if (vote_ack === 1'b1)
      ack_cnt++;
    check_output({name, " ready low with ack"}, 32'(ready), 32'(!vote_ack));
    apply_stimulus(MODE_VOTE, 1'b0, 4'b0000, 2'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    //                mode arm valid    sel  rdy ack col leds
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1}); // arm
    vecs.push_back('{1'b0, 1'b0, 4'b0010, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0}); // vote cand 1
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0}); // unarmed vote
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0}); // tally0
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1}); // tally1
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1}); // arm
    vecs.push_back('{1'b0, 1'b0, 4'b0101, 2'd0, 1'b1, 1'b0, 1'b1, 8'd1}); // collision
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1}); // re-arm no effect
    vecs.push_back('{1'b0, 1'b0, 4'b0100, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0}); // vote cand 2
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1}); // tally2
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0}); // tally0
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1}); // arm
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1}); // disarm by mode
    vecs.push_back('{1'b1, 1'b0, 4'b0001, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1}); // ignored vote
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0}); // tally0 still 0
    vecs.push_back('{1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1}); // arm+vote: vote lost
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1});
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0}); // tally0 still 0
    vecs.push_back('{1'b1, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1}); // arm in result mode

    reset = 1'b1;
    apply_stimulus(MODE_VOTE, 1'b0, 4'b0000, 2'd0);
    check_output("reset ready", 32'(ready), 32'd0);
    check_output("reset ack", 32'(vote_ack), 32'd0);
    check_output("reset collision", 32'(collision), 32'd0);
    check_output("reset leds", 32'(leds), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].mode, vecs[i].arm, vecs[i].valid, vecs[i].sel);
      check_output($sformatf("row%0d ready", i), 32'(ready), 32'(vecs[i].ready));
      check_output($sformatf("row%0d ack", i), 32'(vote_ack), 32'(vecs[i].ack));
      check_output($sformatf("row%0d collision", i), 32'(collision), 32'(vecs[i].coll));
      check_output($sformatf("row%0d leds", i), 32'(leds), 32'(vecs[i].leds));
    end

    // Saturation of candidate 3.
    ack_cnt = 0;
    for (int n = 0; n < 255; n++)
      cast_vote(3, "sat");
    check_output("sat acks 255", 32'(ack_cnt), 32'd255);
    apply_stimulus(MODE_RESULT, 1'b0, 4'b0000, 2'd3);
    check_output("sat leds 255", 32'(leds), 32'hFF);
    cast_vote(3, "sat256");
    check_output("sat acks 256", 32'(ack_cnt), 32'd256);
    apply_stimulus(MODE_RESULT, 1'b0, 4'b0000, 2'd3);
    check_output("sat leds hold", 32'(leds), 32'hFF);
    apply_stimulus(MODE_RESULT, 1'b0, 4'b0000, 2'd2);
    check_output("sat other tally", 32'(leds), 32'd1);

    // Reset while armed.
    apply_stimulus(MODE_VOTE, 1'b1, 4'b0000, 2'd0);
    check_output("pre-reset ready", 32'(ready), 32'd1);
    reset = 1'b1;
    apply_stimulus(MODE_VOTE, 1'b0, 4'b0010, 2'd0);
    check_output("midreset ready", 32'(ready), 32'd0);
    check_output("midreset ack", 32'(vote_ack), 32'd0);
    reset = 1'b0;
    apply_stimulus(MODE_RESULT, 1'b0, 4'b0000, 2'd3);
    check_output("midreset tally3", 32'(leds), 32'd0);
    apply_stimulus(MODE_RESULT, 1'b0, 4'b0000, 2'd1);
    check_output("midreset tally1", 32'(leds), 32'd0);
    apply_stimulus(MODE_RESULT, 1'b0, 4'b0000, 2'd2);
    check_output("midreset tally2", 32'(leds), 32'd0);

`ifdef VOTE_TOTAL_EN
    check_output("total after reset", 32'(total_votes), 32'd0);
    ack_cnt = 0;
    cast_vote(0, "tot");
    cast_vote(0, "tot");
    cast_vote(1, "tot");
    cast_vote(3, "tot");
    check_output("total acks", 32'(ack_cnt), 32'd4);
    check_output("total votes 4", 32'(total_votes), 32'd4);
    apply_stimulus(MODE_RESULT, 1'b0, 4'b0000, 2'd0);
    check_output("total tally0", 32'(leds), 32'd2);
    apply_stimulus(MODE_VOTE, 1'b1, 4'b0000, 2'd0);
    reset = 1'b1;
    apply_stimulus(MODE_VOTE, 1'b0, 4'b0000, 2'd0);
    reset = 1'b0;
    check_output("total cleared", 32'(total_votes), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
